racetrack_memory_array: RTL and testbench

Multi-track, multi-bit domain-wall (racetrack) memory block with a shift-latency model and valid/ready request/response handshakes. It is the parametrised successor to the single-track 64-domain racetrack cell. It adds:
- NUM_TRACKS independent tracks.
- DATA_W-bit domains.
- Per-track head position, with shortest-direction bidirectional shifting.
- Drive-current qualification and an error response.

It sits beside the STT-MRAM cell in the integrated spintronics chip as bulk non-volatile storage.

---
 rtl/racetrack_memory_array.sv | 146 ++++++++++++++
 tb/tb_racetrack_memory_array.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/racetrack_memory_array.sv
// Multi-track racetrack memory: per-track head, shortest-direction domain-wall shifting,
// drive-current qualification and a valid/ready request/response handshake.
module racetrack_memory_array #(
    parameter int NUM_TRACKS        = 4,
    parameter int DOMAINS_PER_TRACK = 64,
    parameter int DATA_W            = 8,
    parameter int SHIFT_CYCLES      = 4,
    parameter int MIN_DRIVE_UA      = 20,
    parameter int TRK_W             = $clog2(NUM_TRACKS),
    parameter int DOM_W             = $clog2(DOMAINS_PER_TRACK)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [TRK_W-1:0]            req_track,
    input  logic [DOM_W-1:0]            req_domain,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic [15:0]                 drive_current_ua,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic                        resp_err,
    output logic                        busy,
    output logic [NUM_TRACKS*DOM_W-1:0] head_pos_flat,
    output logic [31:0]                 shift_count
);

    localparam int DEPTH = NUM_TRACKS * DOMAINS_PER_TRACK;
    localparam int CNT_W = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ACCESS, RESP} state_t;

    state_t                   state;
    logic                     write_q;
    logic [TRK_W-1:0]         trk_q;
    logic [DOM_W-1:0]         dom_q;
    logic [DATA_W-1:0]        wdata_q;
    logic                     dir_fwd_q;
    logic [DOM_W-1:0]         steps_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [DOM_W-1:0]         head [NUM_TRACKS];
    logic [DATA_W-1:0]        mem  [DEPTH];

    logic [DOM_W-1:0]         fwd;
    logic [DOM_W:0]           bwd;
    logic                     take_fwd;
    logic [DOM_W-1:0]         steps;
    logic [TRK_W+DOM_W-1:0]   addr;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Modular distance; when fwd is non-zero bwd < DOMAINS_PER_TRACK, so its low bits suffice.
    always_comb begin
        fwd      = req_domain - head[req_track];
        bwd      = (DOM_W+1)'(DOMAINS_PER_TRACK) - {1'b0, fwd};
        take_fwd = ({1'b0, fwd} <= bwd);
        steps    = take_fwd ? fwd : bwd[DOM_W-1:0];
    end

    assign addr      = {trk_q, dom_q};
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_head
        assign head_pos_flat[t*DOM_W +: DOM_W] = head[t];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            write_q     <= 1'b0;
            trk_q       <= '0;
            dom_q       <= '0;
            wdata_q     <= '0;
            dir_fwd_q   <= 1'b0;
            steps_q     <= '0;
            cnt_q       <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            shift_count <= '0;
            for (int t = 0; t < NUM_TRACKS; t++) head[t] <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        trk_q     <= req_track;
                        dom_q     <= req_domain;
                        wdata_q   <= req_wdata;
                        dir_fwd_q <= take_fwd;
                        steps_q   <= steps;
                        cnt_q     <= '0;
                        if (drive_current_ua < 16'(MIN_DRIVE_UA)) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else if (fwd == '0) begin
                            state <= ACCESS;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q       <= '0;
                        head[trk_q] <= dir_fwd_q ? head[trk_q] + DOM_W'(1)
                                                 : head[trk_q] - DOM_W'(1);
                        shift_count <= sat_inc(shift_count);
                        steps_q     <= steps_q - DOM_W'(1);
                        if (steps_q == DOM_W'(1)) state <= ACCESS;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ACCESS: begin
                    if (write_q) begin
                        mem[addr]  <= wdata_q;
                        resp_rdata <= '0;
                    end else begin
                        resp_rdata <= mem[addr];
                    end
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_racetrack_memory_array.sv
// Bench for racetrack_memory_array: directed vector table, randomized traffic against a
// behavioural model, backpressure and mid-shift reset sequences.
module tb_racetrack_memory_array;

    localparam int NT  = 4;
    localparam int D   = 64;
    localparam int DW  = 8;
    localparam int SC  = 4;
    localparam int MIN = 20;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_write = 1'b0;
    logic [1:0]      req_track = '0;
    logic [5:0]      req_domain = '0;
    logic [DW-1:0]   req_wdata = '0;
    logic [15:0]     drive_current_ua = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [DW-1:0]   resp_rdata;
    logic            resp_err;
    logic            busy;
    logic [23:0]     head_pos_flat;
    logic [31:0]     shift_count;

    racetrack_memory_array #(
        .NUM_TRACKS(NT), .DOMAINS_PER_TRACK(D), .DATA_W(DW),
        .SHIFT_CYCLES(SC), .MIN_DRIVE_UA(MIN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_track(req_track), .req_domain(req_domain), .req_wdata(req_wdata),
        .drive_current_ua(drive_current_ua),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .head_pos_flat(head_pos_flat), .shift_count(shift_count)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Behavioural model: the head simply ends at the target domain after min(fwd,bwd) steps.
    int    mem_m  [NT][D];
    int    head_m [NT];
    longint sc_m;

    typedef struct {
        logic w; int trk; int dom; int wd; int drv;
        int lat; int rd; int err; int h1; int h2; int sc;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            head_m[t] = 0;
            for (int d = 0; d < D; d++) mem_m[t][d] = 0;
        end
        sc_m = 0;
    endtask

    task automatic model_step(input logic w, input int trk, input int dom, input int wd,
                              input int drv, output int lat, output int rd, output int err);
        int fwd, bwd, steps;
        if (drv < MIN) begin
            lat = 1; rd = 0; err = 1;
            return;
        end
        fwd   = (dom - head_m[trk] + D) % D;
        bwd   = D - fwd;
        steps = (fwd <= bwd) ? fwd : bwd;
        head_m[trk] = dom;
        sc_m  = sc_m + steps;
        lat   = steps * SC + 2;
        err   = 0;
        if (w) begin
            mem_m[trk][dom] = wd & 8'hFF;
            rd = 0;
        end else begin
            rd = mem_m[trk][dom];
        end
    endtask

    function automatic logic [23:0] model_flat();
        logic [23:0] f;
        for (int t = 0; t < NT; t++) f[t*6 +: 6] = 6'(head_m[t]);
        return f;
    endfunction

    // Issue one request and return the number of edges until resp_valid is first seen.
    task automatic run_txn(input logic w, input int trk, input int dom, input int wd,
                           input int drv, output int lat);
        int guard = 0;
        while (!req_ready && guard < 1000) begin
            @(posedge clk); #1; guard++;
        end
        req_write        = w;
        req_track        = 2'(trk);
        req_domain       = 6'(dom);
        req_wdata        = 8'(wd);
        drive_current_ua = 16'(drv);
        req_valid        = 1'b1;
        @(posedge clk); #1;
        req_valid        = 1'b0;
        req_write        = 1'($urandom);
        req_track        = 2'($urandom);
        req_domain       = 6'($urandom);
        req_wdata        = 8'($urandom);
        drive_current_ua = 16'($urandom_range(0, 5));
        lat = 1;
        while (!resp_valid && lat < 400) begin
            @(posedge clk); #1; lat++;
        end
        if (!resp_valid) chk("resp_timeout", 64'(lat), 64'(0));
    endtask

    task automatic finish_txn(input int hold);
        logic [DW-1:0] rd0 = resp_rdata;
        logic          e0  = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(resp_valid), 64'(1));
            chk("hold_rdata", 64'({e0, rd0}), 64'({resp_err, resp_rdata}));
            chk("hold_ready", 64'(req_ready), 64'(0));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("release_valid", 64'(resp_valid), 64'(0));
        chk("release_ready", 64'(req_ready), 64'(1));
        chk("release_busy",  64'(busy), 64'(0));
    endtask

    initial begin
        int lat, erd, eerr, elat;

        tbl[0] = '{1'b1, 1,  5, 'hA5, 50,  22, 'h00, 0, 5,  0, 5};
        tbl[1] = '{1'b0, 1,  5, 0,    50,   2, 'hA5, 0, 5,  0, 5};
        tbl[2] = '{1'b0, 1, 63, 0,    50,  26, 'h00, 0, 63, 0, 11};
        tbl[3] = '{1'b0, 1, 31, 0,    50, 130, 'h00, 0, 31, 0, 43};
        tbl[4] = '{1'b1, 2,  9, 'h5A, 10,   1, 'h00, 1, 31, 0, 43};
        tbl[5] = '{1'b0, 2,  9, 0,    50,  38, 'h00, 0, 31, 9, 52};
        tbl[6] = '{1'b0, 1, 31, 0,    20,   2, 'h00, 0, 31, 9, 52};
        tbl[7] = '{1'b1, 0, 32, 'h3C, 19,   1, 'h00, 1, 31, 9, 52};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready",  64'(req_ready), 64'(1));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_busy",       64'(busy), 64'(0));
        chk("rst_rdata_err",  64'({resp_err, resp_rdata}), 64'(0));
        chk("rst_heads",      64'(head_pos_flat), 64'(0));
        chk("rst_shift_cnt",  64'(shift_count), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            model_step(tbl[i].w, tbl[i].trk, tbl[i].dom, tbl[i].wd, tbl[i].drv, elat, erd, eerr);
            run_txn(tbl[i].w, tbl[i].trk, tbl[i].dom, tbl[i].wd, tbl[i].drv, lat);
            chk($sformatf("vec%0d_lat", i),   64'(lat), 64'(tbl[i].lat));
            chk($sformatf("vec%0d_rdata", i), 64'(resp_rdata), 64'(tbl[i].rd));
            chk($sformatf("vec%0d_err", i),   64'(resp_err), 64'(tbl[i].err));
            chk($sformatf("vec%0d_busy", i),  64'(busy), 64'(1));
            chk($sformatf("vec%0d_heads", i), 64'(head_pos_flat),
                64'({6'd0, 6'(tbl[i].h2), 6'(tbl[i].h1), 6'd0}));
            chk($sformatf("vec%0d_shifts", i), 64'(shift_count), 64'(tbl[i].sc));
            finish_txn(0);
        end

        // Backpressure: response must hold for 10 cycles with resp_ready low.
        model_step(1'b0, 1, 5, 0, 40, elat, erd, eerr);
        run_txn(1'b0, 1, 5, 0, 40, lat);
        chk("bp_lat",   64'(lat), 64'(elat));
        chk("bp_rdata", 64'(resp_rdata), 64'(8'hA5));
        finish_txn(10);

        for (int i = 0; i < 40; i++) begin
            logic w   = 1'($urandom);
            int   trk = int'($urandom_range(0, NT-1));
            int   dom = ($urandom % 2 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, D-1));
            int   wd  = int'($urandom_range(0, 255));
            int   drv = int'($urandom_range(0, 60));
            model_step(w, trk, dom, wd, drv, elat, erd, eerr);
            run_txn(w, trk, dom, wd, drv, lat);
            chk($sformatf("rnd%0d_lat", i),    64'(lat), 64'(elat));
            chk($sformatf("rnd%0d_rdata", i),  64'(resp_rdata), 64'(erd));
            chk($sformatf("rnd%0d_err", i),    64'(resp_err), 64'(eerr));
            chk($sformatf("rnd%0d_heads", i),  64'(head_pos_flat), 64'(model_flat()));
            chk($sformatf("rnd%0d_shifts", i), 64'(shift_count), 64'(sc_m));
            finish_txn(int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a 5-step write on a freshly reset array.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        req_write = 1'b1; req_track = 2'd3; req_domain = 6'd5; req_wdata = 8'h77;
        drive_current_ua = 16'd50; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy_before", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'(1));
        chk("mid_rst_valid", 64'(resp_valid), 64'(0));
        chk("mid_rst_busy",  64'(busy), 64'(0));
        chk("mid_rst_heads", 64'(head_pos_flat), 64'(0));
        chk("mid_rst_shift", 64'(shift_count), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_step(1'b0, 3, 5, 0, 50, elat, erd, eerr);
        run_txn(1'b0, 3, 5, 0, 50, lat);
        chk("post_rst_lat",   64'(lat), 64'(elat));
        chk("post_rst_rdata", 64'(resp_rdata), 64'(0));
        chk("post_rst_heads", 64'(head_pos_flat), 64'(model_flat()));
        finish_txn(0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
